// File: rtl/edvs_pkg.sv
// Shared definitions for the eDVS command sequencer: FSM encoding, the default
// command table and the command-index width helper.
package edvs_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP       = 3'd5,
    S_NEXT      = 3'd6
  } state_t;

  localparam int DEF_NUM_CMDS = 4;
  localparam int DEF_MAX_LEN  = 8;

  // Slots 3..0 hold "??\n", "R\n", "-E\n", "+E\n", right-aligned in 64-bit slots.
  localparam logic [DEF_NUM_CMDS*DEF_MAX_LEN*8-1:0] DEF_CMD_TABLE = {
    64'h0000_0000_003F_3F0A,
    64'h0000_0000_0000_520A,
    64'h0000_0000_002D_450A,
    64'h0000_0000_002B_450A
  };

  localparam logic [DEF_NUM_CMDS*8-1:0] DEF_CMD_LENS = {8'd3, 8'd2, 8'd3, 8'd3};

  function automatic int cw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edvs_req_fifo.sv
// Synchronous request FIFO with flush; full/empty derived from wrap-bit pointers.
module edvs_req_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/edvs_cmd_sequencer.sv
// Queues command requests and streams the selected ASCII command string, one byte per
// transmitter handshake, to the UART feeding the eDVS RX pin.
module edvs_cmd_sequencer
  import edvs_pkg::*;
#(
  parameter int                              NUM_CMDS   = DEF_NUM_CMDS,
  parameter int                              MAX_LEN    = DEF_MAX_LEN,
  parameter logic [NUM_CMDS*MAX_LEN*8-1:0]   CMD_TABLE  = DEF_CMD_TABLE,
  parameter logic [NUM_CMDS*8-1:0]           CMD_LENS   = DEF_CMD_LENS,
  parameter int                              REQ_DEPTH  = 4,
  parameter int                              GAP_CYCLES = 0,
  parameter int                              TX_TIMEOUT = 1024,
  localparam int                             CW         = cw_of(NUM_CMDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [CW-1:0] req_cmd,
  output logic          req_ready,
  input  logic          abort,
  output logic [7:0]    tx_byte,
  output logic          tx_wr_en,
  input  logic          tx_busy,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] done_cmd,
  output logic          err,
  output logic [2:0]    fsm_state
);

  localparam int SLOT_W = MAX_LEN * 8;
  localparam int KW     = $clog2(MAX_LEN) + 1;
  localparam int TW     = $clog2(TX_TIMEOUT) + 1;
  localparam int GW     = $clog2(GAP_CYCLES + 1) + 1;

  state_t         state;
  logic [CW-1:0]  cmd;
  logic [KW-1:0]  k;
  logic [TW-1:0]  timer;
  logic [GW-1:0]  gap_cnt;
  logic           aborted;

  logic [CW-1:0]  fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           req_fire;
  logic           cmd_ok;
  logic           push;
  logic           pop;
  logic           bad_req;

  logic [SLOT_W-1:0] slot;
  logic [7:0]        cur_len;
  logic [7:0]        table_byte;
  logic              last_byte;

  // Handshake: a request is taken on a cycle where req_valid and req_ready are both high;
  // a request presented together with abort is discarded.
  assign req_ready = !fifo_full;
  assign req_fire  = req_valid && req_ready && !abort;
  assign cmd_ok    = int'(req_cmd) < NUM_CMDS;
  assign push      = req_fire && cmd_ok;
  assign bad_req   = req_fire && !cmd_ok;
  assign pop       = (state == S_IDLE) && !fifo_empty && !abort;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign fsm_state = state;

  edvs_req_fifo #(
    .WIDTH (CW),
    .DEPTH (REQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (push),
    .din   (req_cmd),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Strings are right-aligned, so byte k counts down from the top of the used part of the slot.
  always_comb begin
    slot       = SLOT_W'(CMD_TABLE >> (int'(cmd) * SLOT_W));
    cur_len    = 8'(CMD_LENS >> (int'(cmd) * 8));
    table_byte = 8'(slot >> (8 * (int'(cur_len) - 1 - int'(k))));
    last_byte  = (int'(k) == int'(cur_len) - 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cmd      <= '0;
      k        <= '0;
      timer    <= '0;
      gap_cnt  <= '0;
      aborted  <= 1'b0;
      tx_byte  <= '0;
      tx_wr_en <= 1'b0;
      done     <= 1'b0;
      done_cmd <= '0;
      err      <= 1'b0;
    end else begin
      tx_wr_en <= 1'b0;
      done     <= 1'b0;
      err      <= bad_req;
      case (state)
        S_IDLE: begin
          aborted <= 1'b0;
          if (pop) begin
            cmd   <= fifo_dout;
            k     <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) state <= S_IDLE;
          else begin
            tx_byte <= table_byte;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort) state <= S_IDLE;
          else if (!tx_busy) begin
            tx_wr_en <= 1'b1;
            timer    <= '0;
            state    <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          // Once a byte is written it must finish on the wire, so abort is only remembered here.
          if (abort) aborted <= 1'b1;
          if (tx_busy) state <= S_WAIT_DONE;
          else if (timer == TW'(TX_TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else timer <= timer + TW'(1);
        end
        S_WAIT_DONE: begin
          if (abort) aborted <= 1'b1;
          if (!tx_busy) begin
            gap_cnt <= '0;
            if (abort || aborted) state <= S_IDLE;
            else if (GAP_CYCLES > 0) state <= S_GAP;
            else state <= S_NEXT;
          end
        end
        S_GAP: begin
          if (abort) state <= S_IDLE;
          else if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= S_NEXT;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        S_NEXT: begin
          if (abort) state <= S_IDLE;
          else if (last_byte) begin
            done     <= 1'b1;
            done_cmd <= cmd;
            state    <= S_IDLE;
          end else begin
            k     <= k + KW'(1);
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edvs_cmd_sequencer.sv
// Bench for edvs_cmd_sequencer: transmitter model, byte/done scoreboard against the
// ASCII command strings, directed scenarios and a randomized request stream.
module tb_edvs_cmd_sequencer;

  localparam int TX_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_cmd = 2'd0;
  logic       abort = 1'b0;
  logic       req_ready, tx_wr_en, tx_busy, busy, done, err;
  logic [7:0] tx_byte;
  logic [1:0] done_cmd;
  logic [2:0] fsm_state;

  int total = 0, bad = 0, cyc = 0;
  int byte_cnt = 0, done_cnt = 0, err_cnt = 0, last_wr_cyc = 0, err_cyc = 0;
  int done_exp = 0, err_exp = 0, busy_cnt = 0;
  bit model_dead = 1'b0;
  logic [7:0] exp_q[$];
  logic [1:0] exp_done_q[$];

  // Three commands so that index 3 is representable on the 2-bit req_cmd and is out of range.
  edvs_cmd_sequencer #(
    .NUM_CMDS   (3),
    .MAX_LEN    (8),
    .CMD_TABLE  ({64'h0000_0000_0000_520A, 64'h0000_0000_002D_450A, 64'h0000_0000_002B_450A}),
    .CMD_LENS   ({8'd2, 8'd3, 8'd3}),
    .REQ_DEPTH  (4),
    .GAP_CYCLES (0),
    .TX_TIMEOUT (TX_TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ready (req_ready),
    .abort     (abort),
    .tx_byte   (tx_byte),
    .tx_wr_en  (tx_wr_en),
    .tx_busy   (tx_busy),
    .busy      (busy),
    .done      (done),
    .done_cmd  (done_cmd),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises the cycle after a write and holds for 10 cycles.
  always @(posedge clk) begin
    if (tx_wr_en && !model_dead) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string cmd_str(input int c);
    case (c)
      0:       return "+E\n";
      1:       return "-E\n";
      default: return "R\n";
    endcase
  endfunction

  function automatic void push_cmd(input int c, input int nbytes, input bit with_done);
    string s;
    s = cmd_str(c);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(s[i]);
    if (with_done) begin
      exp_done_q.push_back(2'(c));
      done_exp++;
    end
  endfunction

  // Scoreboard
  always @(negedge clk) begin : monitor
    logic [7:0] eb;
    logic [1:0] ec;
    if (!reset) begin
      if (tx_wr_en) begin
        check("wr_en_while_busy", {31'b0, tx_busy}, 32'd0);
        if (exp_q.size() > 0) eb = exp_q.pop_front();
        else eb = 8'bx;
        check("tx_byte", {24'b0, tx_byte}, {24'b0, eb});
        byte_cnt++;
        last_wr_cyc = cyc;
      end
      if (done) begin
        if (exp_done_q.size() > 0) ec = exp_done_q.pop_front();
        else ec = 2'bx;
        check("done_cmd", {30'b0, done_cmd}, {30'b0, ec});
        done_cnt++;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_req(input logic [1:0] c);
    int n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_cmd   = c;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic send_req(input logic [1:0] c);
    drive_req(c);
    if (c < 2'd3) push_cmd(int'(c), cmd_str(int'(c)).len(), 1'b1);
    else err_exp++;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(busy == 1'b0 && !tx_busy && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'b0, n < budget}, 32'd1);
    tick(2);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n = 0;
    while (byte_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("byte_wait", {31'b0, byte_cnt >= target}, 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b0, d0, n;
    int seq[5] = '{0, 1, 0, 1, 0};
    logic [1:0] c;

    // Reset state
    @(negedge clk);
    check("rst_wr_en", {31'b0, tx_wr_en}, 32'd0);
    check("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_done_cmd", {30'b0, done_cmd}, 32'd0);
    reset = 1'b0;
    tick(1);

    // Single "+E\n"
    send_req(2'd0);
    check("busy_after_req", {31'b0, busy}, 32'd1);
    wait_idle(300);
    check("single_bytes", byte_cnt, 3);
    check("single_done", done_cnt, 1);

    // Back-to-back: one in flight plus four queued fills the FIFO
    foreach (seq[i]) send_req(2'(seq[i]));
    check("ready_low_full", {31'b0, req_ready}, 32'd0);
    check("busy_full", {31'b0, busy}, 32'd1);
    wait_idle(1000);
    check("b2b_bytes", byte_cnt, 18);
    check("b2b_done", done_cnt, 6);

    // Out-of-range index
    drive_req(2'd3);
    err_exp++;
    check("bad_idx_err", {31'b0, err}, 32'd1);
    check("bad_idx_not_queued", {31'b0, busy}, 32'd0);
    tick(1);
    check("bad_idx_pulse", {31'b0, err}, 32'd0);
    check("bad_idx_err_cnt", err_cnt, err_exp);
    check("bad_idx_no_tx", byte_cnt, 18);

    // Transmitter never answers: first command dropped, next one still sent
    model_dead = 1'b1;
    b0 = byte_cnt;
    d0 = done_cnt;
    push_cmd(0, 1, 1'b0);
    drive_req(2'd0);
    send_req(2'd1);
    n = 0;
    while (err_cnt == err_exp && n < 2 * TX_TIMEOUT + 50) begin
      @(negedge clk);
      n++;
    end
    model_dead = 1'b0;
    err_exp++;
    check("timeout_err", err_cnt, err_exp);
    check("timeout_latency", err_cyc - last_wr_cyc, TX_TIMEOUT);
    check("timeout_no_done", done_cnt, d0);
    wait_idle(400);
    check("timeout_next_done", done_cnt, d0 + 1);
    check("timeout_bytes", byte_cnt, b0 + 4);

    // Abort during byte 2 of "-E\n" with two more queued; a request alongside abort is dropped
    b0 = byte_cnt;
    d0 = done_cnt;
    push_cmd(1, 2, 1'b0);
    drive_req(2'd1);
    drive_req(2'd0);
    drive_req(2'd2);
    wait_bytes(b0 + 2, 200);
    tick(2);
    abort     = 1'b1;
    req_valid = 1'b1;
    req_cmd   = 2'd0;
    tick(1);
    abort     = 1'b0;
    req_valid = 1'b0;
    check("abort_byte_in_flight", {31'b0, busy}, 32'd1);
    wait_idle(300);
    check("abort_idle", {31'b0, busy}, 32'd0);
    check("abort_no_done", done_cnt, d0);
    check("abort_bytes", byte_cnt, b0 + 2);

    // Randomized request stream, occasional bad index
    for (int i = 0; i < 24; i++) begin
      tick($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      send_req(c);
    end
    wait_idle(5000);
    check("rand_done_cnt", done_cnt, done_exp);
    check("rand_err_cnt", err_cnt, err_exp);

    // Asynchronous reset in the middle of a byte
    b0 = byte_cnt;
    push_cmd(1, 1, 1'b0);
    drive_req(2'd1);
    wait_bytes(b0 + 1, 200);
    tick(3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_wr_en", {31'b0, tx_wr_en}, 32'd0);
    check("mid_rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_err", {31'b0, err}, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    send_req(2'd2);
    wait_idle(300);
    check("post_rst_bytes", byte_cnt, b0 + 3);
    check("post_rst_done", done_cnt, done_exp);

    check("exp_q_drained", exp_q.size(), 0);
    check("exp_done_drained", exp_done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
